sign_extend_unit: RTL and testbench

// - MIPS immediate extender: widens the 16-bit instruction immediate to a 32-bit datapath operand.
// - Sits between the decode stage and the ALU / branch-target adder.
// - Supports four modes: signed, unsigned, LUI upper placement, and branch offset (sign-extend, then <<2).
// - Output is registered: one clock of latency, with a valid flag.
//

---
 rtl/sign_extend_unit.sv | 50 +++++
 tb/tb_sign_extend_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/sign_extend_unit.sv
// Immediate extender: widens the instruction immediate to a datapath operand.
// Sign, zero, LUI and branch-offset modes; one registered cycle of latency.
module sign_extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  In,
  output logic [OUT_W-1:0] Out,
  output logic             out_valid
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sext;
  logic [OUT_W-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  assign sext = {{EXT_W{In[IN_W-1]}}, In};

  always_comb begin
    out_d   = out_q;
    valid_d = in_valid;
    if (in_valid) begin
      unique case (1'b1)
        (mode == 2'b00): out_d = sext;
        (mode == 2'b01): out_d = {{EXT_W{1'b0}}, In};
        (mode == 2'b10): out_d = {In, {EXT_W{1'b0}}};
        (mode == 2'b11): out_d = {sext[OUT_W-3:0], 2'b00};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign Out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Bench for sign_extend_unit: directed cases plus a random stream
// checked against an arithmetic reference model.
module tb_sign_extend_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  mode;
  logic [15:0] In;
  logic [31:0] Out;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_out;
  logic        exp_v;

  sign_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .mode      (mode),
    .In        (In),
    .Out       (Out),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Model: interpret the immediate as an integer and scale it.
  function automatic logic [31:0] ref_ext(input logic [1:0] m,
                                          input logic [15:0] v);
    longint s;
    longint u;
    longint r;
    u = longint'(v);
    s = (u >= 32768) ? u - 65536 : u;
    case (m)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = u * 65536;
      default: r = s * 4;
    endcase
    return r[31:0];
  endfunction

  task automatic step(input logic r, input logic v,
                      input logic [1:0] m, input logic [15:0] d);
    reset    = r;
    in_valid = v;
    mode     = m;
    In       = d;
    @(posedge clk);
    #1;
    if (r) begin
      exp_out = '0;
      exp_v   = 1'b0;
    end else begin
      exp_v = v;
      if (v) exp_out = ref_ext(m, d);
    end
  endtask

  task automatic look(input string tag);
    chk({tag, "_out"}, Out, exp_out);
    chk({tag, "_vld"}, {31'b0, out_valid}, {31'b0, exp_v});
  endtask

  initial begin
    exp_out = '0;
    exp_v   = 1'b0;
    step(1'b1, 1'b0, 2'd0, 16'h0);
    step(1'b1, 1'b0, 2'd0, 16'h0);
    chk("rst_out", Out, 32'h0);
    chk("rst_vld", {31'b0, out_valid}, 32'h0);

    step(1'b0, 1'b1, 2'd0, 16'hFFF6);
    chk("sx_neg", Out, 32'hFFFF_FFF6);
    chk("sx_neg_vld", {31'b0, out_valid}, 32'h1);
    step(1'b0, 1'b1, 2'd0, 16'h000A);
    chk("sx_pos", Out, 32'h0000_000A);
    chk("sx_pos_vld", {31'b0, out_valid}, 32'h1);
    step(1'b0, 1'b1, 2'd0, 16'h8000);
    chk("sx_min", Out, 32'hFFFF_8000);
    step(1'b0, 1'b1, 2'd0, 16'h7FFF);
    chk("sx_max", Out, 32'h0000_7FFF);
    step(1'b0, 1'b1, 2'd0, 16'h0000);
    chk("sx_zero", Out, 32'h0);
    step(1'b0, 1'b1, 2'd1, 16'hFFF6);
    chk("zx", Out, 32'h0000_FFF6);
    step(1'b0, 1'b1, 2'd2, 16'hFFF6);
    chk("lui", Out, 32'hFFF6_0000);
    step(1'b0, 1'b1, 2'd2, 16'h1234);
    chk("lui2", Out, 32'h1234_0000);
    step(1'b0, 1'b1, 2'd3, 16'hFFF6);
    chk("br", Out, 32'hFFFF_FFD8);
    step(1'b0, 1'b1, 2'd3, 16'hFFFF);
    chk("br_m1", Out, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 2'd3, 16'h7FFF);
    chk("br_max", Out, 32'h0001_FFFC);

    step(1'b0, 1'b0, 2'd0, 16'h1111);
    chk("hold_out", Out, 32'h0001_FFFC);
    chk("hold_vld", {31'b0, out_valid}, 32'h0);

    step(1'b0, 1'b1, 2'd1, 16'hABCD);
    step(1'b1, 1'b1, 2'd1, 16'h5555);
    chk("rst_mid_out", Out, 32'h0);
    chk("rst_mid_vld", {31'b0, out_valid}, 32'h0);

    for (int i = 0; i < 6000; i++) begin
      logic r, v;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      step(r, v, 2'($urandom_range(0, 3)), 16'($urandom));
      look("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
